// File: rtl/spram_seq_zxn.sv
// spram_seq_zxn: FILL / COPY / SUM sequencer that owns the single port of one spram_zxN.
// RAM-side outputs are registered; write data bypasses the register only in the COPY write phase.
module spram_seq_zxn #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 8
) (
    input  logic                 clocka,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           cmd,
    input  logic                 dir,
    input  logic [ADDRWIDTH-1:0] src_addr,
    input  logic [ADDRWIDTH-1:0] dst_addr,
    input  logic [ADDRWIDTH:0]   length,
    input  logic [DATAWIDTH-1:0] fill_data,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [DATAWIDTH-1:0] result,
    output logic [ADDRWIDTH-1:0] ram_address,
    output logic [DATAWIDTH-1:0] ram_data,
    output logic                 ram_wren,
    input  logic [DATAWIDTH-1:0] ram_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CRD,
        S_CWR,
        S_SUM,
        S_SUMLAST,
        S_DONE
    } state_t;

    localparam logic [1:0]           CMD_FILL = 2'b00;
    localparam logic [1:0]           CMD_COPY = 2'b01;
    localparam logic [1:0]           CMD_SUM  = 2'b10;
    localparam logic [1:0]           CMD_RSVD = 2'b11;
    localparam logic [ADDRWIDTH-1:0] ADDR_ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRWIDTH:0]   CNT_ONE  = {{ADDRWIDTH{1'b0}}, 1'b1};

    state_t                 state_q;
    logic [ADDRWIDTH:0]     cnt_q;
    logic [ADDRWIDTH-1:0]   srcPtr_q;
    logic [ADDRWIDTH-1:0]   dstPtr_q;
    logic                   dir_q;
    logic [DATAWIDTH-1:0]   fillData_q;
    logic [DATAWIDTH-1:0]   acc_q;
    logic                   sumValid_q;
    logic [ADDRWIDTH-1:0]   address_q;
    logic                   wren_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic [DATAWIDTH-1:0]   result_q;

    logic [ADDRWIDTH-1:0]   step_d;
    logic [ADDRWIDTH-1:0]   srcNext_d;
    logic [ADDRWIDTH-1:0]   dstNext_d;
    logic [ADDRWIDTH-1:0]   addrNext_d;
    logic [ADDRWIDTH:0]     cntNext_d;
    logic [DATAWIDTH-1:0]   accNext_d;
    logic                   lastWord_d;

    // COPY pointers step by +1 or -1 (all ones); FILL and SUM always walk upwards.
    always_comb begin
        step_d     = dir_q ? {ADDRWIDTH{1'b1}} : ADDR_ONE;
        srcNext_d  = srcPtr_q + step_d;
        dstNext_d  = dstPtr_q + step_d;
        addrNext_d = address_q + ADDR_ONE;
        cntNext_d  = cnt_q - CNT_ONE;
        accNext_d  = acc_q + ram_q;
        lastWord_d = (cnt_q == CNT_ONE);
    end

    always_ff @(posedge clocka) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            srcPtr_q   <= '0;
            dstPtr_q   <= '0;
            dir_q      <= 1'b0;
            fillData_q <= '0;
            acc_q      <= '0;
            sumValid_q <= 1'b0;
            address_q  <= '0;
            wren_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    wren_q <= 1'b0;
                    if (start) begin
                        acc_q      <= '0;
                        sumValid_q <= 1'b0;
                        err_q      <= 1'b0;
                        dir_q      <= dir;
                        cnt_q      <= length;
                        srcPtr_q   <= src_addr;
                        dstPtr_q   <= dst_addr;
                        fillData_q <= fill_data;
                        if (cmd == CMD_RSVD || length == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= (cmd == CMD_RSVD);
                        end else begin
                            busy_q <= 1'b1;
                            case (cmd)
                                CMD_FILL: begin
                                    state_q   <= S_FILL;
                                    address_q <= dst_addr;
                                    wren_q    <= 1'b1;
                                end
                                CMD_COPY: begin
                                    state_q   <= S_CRD;
                                    address_q <= src_addr;
                                end
                                default: begin
                                    state_q   <= S_SUM;
                                    address_q <= src_addr;
                                end
                            endcase
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    if (abort) begin
                        state_q <= S_DONE;
                        wren_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        case (state_q)
                            S_FILL: begin
                                if (lastWord_d) begin
                                    state_q <= S_DONE;
                                    wren_q  <= 1'b0;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    address_q <= addrNext_d;
                                    cnt_q     <= cntNext_d;
                                end
                            end
                            S_CRD: begin
                                state_q   <= S_CWR;
                                address_q <= dstPtr_q;
                                wren_q    <= 1'b1;
                                srcPtr_q  <= srcNext_d;
                            end
                            S_CWR: begin
                                wren_q <= 1'b0;
                                if (lastWord_d) begin
                                    state_q <= S_DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q   <= S_CRD;
                                    address_q <= srcPtr_q;
                                    dstPtr_q  <= dstNext_d;
                                    cnt_q     <= cntNext_d;
                                end
                            end
                            S_SUM: begin
                                // The first SUM cycle has no read data returned yet.
                                sumValid_q <= 1'b1;
                                if (sumValid_q) begin
                                    acc_q <= accNext_d;
                                end
                                if (lastWord_d) begin
                                    state_q <= S_SUMLAST;
                                end else begin
                                    address_q <= addrNext_d;
                                    cnt_q     <= cntNext_d;
                                end
                            end
                            S_SUMLAST: begin
                                result_q <= accNext_d;
                                state_q  <= S_DONE;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;
    assign ram_address = address_q;
    assign ram_wren    = wren_q;
    assign ram_data    = (state_q == S_CWR) ? ram_q : fillData_q;

endmodule
